// File: rtl/uart_rx_oversample.sv
// uart_rx_oversample: oversampling UART receiver.
// Frame: start bit, Data_length data bits LSB first, optional parity bit, one stop bit.
// The line is synchronized, timed by a free-running oversample tick, and decoded by a
// six-state FSM that reports each completed frame with a one-cycle rx_done strobe.
// Optional build macro: UART_RX_MAJORITY_EN -- each bit value is the 2-of-3 majority of
// the samples at s = OVERSAMPLE/2-2, OVERSAMPLE/2-1, OVERSAMPLE/2 instead of a single sample.
module uart_rx_oversample #(
  parameter int Data_length = 8,
  parameter int parity_en   = 1,
  parameter int Baud_div    = 27,
  parameter int OVERSAMPLE  = 16
) (
  input  logic                   rx_clk,
  input  logic                   rst,
  input  logic                   serial_in,
  input  logic                   parity_type,
  output logic                   baudraterx,
  output logic [Data_length-1:0] data_out,
  output logic                   rx_done,
  output logic                   parity_error,
  output logic                   frame_error,
  output logic                   error
);

  localparam int DW = (Baud_div > 1) ? $clog2(Baud_div) : 1;
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = (Data_length > 1) ? $clog2(Data_length) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(Baud_div - 1);
  localparam logic [SW-1:0] S_LAST   = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(Data_length - 1);

`ifdef UART_RX_MAJORITY_EN
  localparam logic [SW-1:0] S_PRE0 = SW'(OVERSAMPLE / 2 - 2);
  localparam logic [SW-1:0] S_PRE1 = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_DEC  = SW'(OVERSAMPLE / 2);
`else
  localparam logic [SW-1:0] S_DEC  = SW'(OVERSAMPLE / 2 - 1);
`endif

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } state_t;

  // Synchronizer and tick divider
  logic                   r_sync1;
  logic                   r_sync2;
  logic [DW-1:0]          r_div;
  logic                   r_tick;

  // FSM state and datapath registers
  state_t                 r_state;
  logic [SW-1:0]          r_s;
  logic [BW-1:0]          r_bit;
  logic [Data_length-1:0] r_shift;
  logic                   r_par_err;
  logic [Data_length-1:0] r_data;
  logic                   r_done;
  logic                   r_perr;
  logic                   r_ferr;

  // Next-state values from the combinational process
  state_t                 w_state_nxt;
  logic [SW-1:0]          w_s_nxt;
  logic [BW-1:0]          w_bit_nxt;
  logic [Data_length-1:0] w_shift_nxt;
  logic                   w_par_err_nxt;
  logic [Data_length-1:0] w_data_nxt;
  logic                   w_done_nxt;
  logic                   w_perr_nxt;
  logic                   w_ferr_nxt;

  // Bit value decided at the S_DEC tick
  logic                   w_bit;

  // Two-flop synchronizer; idles high so reset never looks like a start edge
  always_ff @(posedge rx_clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= serial_in;
      r_sync2 <= r_sync1;
    end
  end

  // Free-running divider producing a one-cycle oversample tick at each wrap
  always_ff @(posedge rx_clk or negedge rst) begin
    if (!rst) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else if (r_div == DIV_LAST) begin
      r_div  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_div  <= r_div + DW'(1);
      r_tick <= 1'b0;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic r_maj0;
  logic r_maj1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Capture the two early votes; the third is the live sample at S_DEC
  always_ff @(posedge rx_clk or negedge rst) begin
    if (!rst) begin
      r_maj0 <= 1'b1;
      r_maj1 <= 1'b1;
    end else if (r_tick) begin
      if (r_s == S_PRE0) r_maj0 <= r_sync2;
      if (r_s == S_PRE1) r_maj1 <= r_sync2;
    end
  end

  assign w_bit = maj3(r_maj0, r_maj1, r_sync2);
`else
  assign w_bit = r_sync2;
`endif

  // FSM state, counters, shift register and reported results
  always_ff @(posedge rx_clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_s       <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_par_err <= 1'b0;
      r_data    <= '0;
      r_done    <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_s       <= w_s_nxt;
      r_bit     <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
      r_par_err <= w_par_err_nxt;
      r_data    <= w_data_nxt;
      r_done    <= w_done_nxt;
      r_perr    <= w_perr_nxt;
      r_ferr    <= w_ferr_nxt;
    end
  end

  // Next-state and frame decoding; everything advances only on a tick
  always_comb begin
    w_state_nxt   = r_state;
    w_s_nxt       = r_s;
    w_bit_nxt     = r_bit;
    w_shift_nxt   = r_shift;
    w_par_err_nxt = r_par_err;
    w_data_nxt    = r_data;
    w_done_nxt    = 1'b0;
    w_perr_nxt    = r_perr;
    w_ferr_nxt    = r_ferr;
    if (r_tick) begin
      case (r_state)
        IDLE: begin
          if (!r_sync2) begin
            w_s_nxt     = '0;
            w_state_nxt = START;
          end
        end
        START: begin
          // A confirmed start keeps counting to the end of the start bit so that
          // the data bits are sampled at their own midpoints.
          w_s_nxt = r_s + SW'(1);
          if ((r_s == S_DEC) && w_bit) begin
            w_s_nxt     = '0;
            w_state_nxt = IDLE;
          end else if (r_s == S_LAST) begin
            w_s_nxt       = '0;
            w_bit_nxt     = '0;
            w_par_err_nxt = 1'b0;
            w_state_nxt   = DATA;
          end
        end
        DATA: begin
          w_s_nxt = r_s + SW'(1);
          if (r_s == S_DEC) w_shift_nxt = {w_bit, r_shift[Data_length-1:1]};
          if (r_s == S_LAST) begin
            w_s_nxt = '0;
            if (r_bit == BIT_LAST) begin
              w_state_nxt = (parity_en != 0) ? PARITY : STOP;
            end else begin
              w_bit_nxt = r_bit + BW'(1);
            end
          end
        end
        PARITY: begin
          w_s_nxt = r_s + SW'(1);
          if (r_s == S_DEC) w_par_err_nxt = w_bit ^ (^r_shift) ^ parity_type;
          if (r_s == S_LAST) begin
            w_s_nxt     = '0;
            w_state_nxt = STOP;
          end
        end
        STOP: begin
          w_s_nxt = r_s + SW'(1);
          if (r_s == S_DEC) begin
            w_data_nxt  = r_shift;
            w_perr_nxt  = (parity_en != 0) && r_par_err;
            w_ferr_nxt  = ~w_bit;
            w_done_nxt  = 1'b1;
            w_s_nxt     = '0;
            w_state_nxt = w_bit ? IDLE : WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          if (r_sync2) w_state_nxt = IDLE;
        end
        default: begin
          w_s_nxt     = '0;
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  assign baudraterx   = r_tick;
  assign data_out     = r_data;
  assign rx_done      = r_done;
  assign parity_error = r_perr;
  assign frame_error  = r_ferr;
  assign error        = r_perr | r_ferr;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// tb_uart_rx_oversample: self-checking bench for uart_rx_oversample.
// Two instances: A with parity, B without parity, both Baud_div=4, OVERSAMPLE=16.
module tb_uart_rx_oversample;

  localparam int BIT = 64;                  // rx_clk cycles per bit
  localparam int LAT_A = 10 * BIT + BIT / 2; // start edge to stop midpoint, parity build

  logic       clk = 1'b0;
  logic       rst;
  logic       line_a, line_b, ptype;
  logic       tick_a, done_a, pe_a, fe_a, err_a;
  logic [7:0] dout_a;
  logic       tick_b, done_b, pe_b, fe_b, err_b;
  logic [7:0] dout_b;

  uart_rx_oversample #(.Data_length(8), .parity_en(1), .Baud_div(4), .OVERSAMPLE(16)) u_dut_a (
    .rx_clk(clk), .rst(rst), .serial_in(line_a), .parity_type(ptype),
    .baudraterx(tick_a), .data_out(dout_a), .rx_done(done_a),
    .parity_error(pe_a), .frame_error(fe_a), .error(err_a)
  );

  uart_rx_oversample #(.Data_length(8), .parity_en(0), .Baud_div(4), .OVERSAMPLE(16)) u_dut_b (
    .rx_clk(clk), .rst(rst), .serial_in(line_b), .parity_type(ptype),
    .baudraterx(tick_b), .data_out(dout_b), .rx_done(done_b),
    .parity_error(pe_b), .frame_error(fe_b), .error(err_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       er;
    int         cyc;
  } obs_t;

  typedef struct {
    logic [7:0] d;
    logic       pt;
    logic       pbit;
    logic       stopb;
    logic [7:0] ed;
    logic       epe;
    logic       efe;
  } vec_t;

  obs_t q_a[$];
  obs_t q_b[$];
  obs_t o_mon;
  int   cyc = 0;
  int   consec = 0;
  logic prev_a = 1'b0, prev_b = 1'b0;
  int   edge_a = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  // Monitor: record every completion strobe away from the active edge
  always @(negedge clk) begin
    cyc++;
    if (done_a) begin
      o_mon.d = dout_a; o_mon.pe = pe_a; o_mon.fe = fe_a; o_mon.er = err_a; o_mon.cyc = cyc;
      q_a.push_back(o_mon);
    end
    if (done_b) begin
      o_mon.d = dout_b; o_mon.pe = pe_b; o_mon.fe = fe_b; o_mon.er = err_b; o_mon.cyc = cyc;
      q_b.push_back(o_mon);
    end
    if (done_a && prev_a) consec++;
    if (done_b && prev_b) consec++;
    prev_a = done_a;
    prev_b = done_b;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected within [%0d,%0d]", nm, act, lo, hi);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input bit which, input logic v, input int nbits);
    if (which) line_b = v; else line_a = v;
    repeat (nbits * BIT) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input bit which, input logic [7:0] d, input bit has_par,
                            input logic pbit, input logic stopb, input int stop_bits);
    if (!which) edge_a = cyc;
    drive_bit(which, 1'b0, 1);
    for (int i = 0; i < 8; i++) drive_bit(which, d[i], 1);
    if (has_par) drive_bit(which, pbit, 1);
    drive_bit(which, stopb, stop_bits);
    if (which) line_b = 1'b1; else line_a = 1'b1;
  endtask

  // Reference parity bit: even -> XOR of data, odd -> its inverse
  function automatic logic model_parity(input logic [7:0] d, input logic pt);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return logic'((ones % 2) != 0) ^ pt;
  endfunction

  task automatic expect_a(input string nm, input logic [7:0] d, input logic pe, input logic fe);
    obs_t o;
    int   w = 0;
    while (q_a.size() == 0 && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    chk({nm, "_done_seen"}, q_a.size() != 0, 1);
    if (q_a.size() == 0) return;
    o = q_a.pop_front();
    chk({nm, "_data"}, o.d, d);
    chk({nm, "_parity_error"}, o.pe, pe);
    chk({nm, "_frame_error"}, o.fe, fe);
    chk({nm, "_error"}, o.er, pe | fe);
    chk_rng({nm, "_latency"}, o.cyc - edge_a, LAT_A, LAT_A + 16);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    obs_t b0, b1;
    int   nt;
    logic [7:0] saved_d;
    logic saved_e;
    logic [7:0] rd;
    logic rpt, rpb, rst_b;
    bit   bad;

    tbl[0] = '{8'h01, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[2] = '{8'h7F, 1'b0, 1'b1, 1'b1, 8'h7F, 1'b0, 1'b0};
    tbl[3] = '{8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
    tbl[4] = '{8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[5] = '{8'hC3, 1'b0, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1};
    tbl[6] = '{8'h96, 1'b1, 1'b0, 1'b0, 8'h96, 1'b1, 1'b1};

    rst = 1'b0; line_a = 1'b1; line_b = 1'b1; ptype = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_data_out", dout_a, 8'h00);
    chk("rst_rx_done", done_a, 1'b0);
    chk("rst_parity_error", pe_a, 1'b0);
    chk("rst_frame_error", fe_a, 1'b0);
    chk("rst_error", err_a, 1'b0);
    chk("rst_baudraterx", tick_a, 1'b0);
    rst = 1'b1;

    nt = 0;
    repeat (40) begin
      @(negedge clk);
      if (tick_a) nt++;
    end
    chk("tick_rate", nt, 10);
    idle(3);

    // Table-driven frames on the parity instance
    for (int i = 0; i < 7; i++) begin
      ptype = tbl[i].pt;
      send_frame(1'b0, tbl[i].d, 1'b1, tbl[i].pbit, tbl[i].stopb, 1);
      expect_a($sformatf("tbl%0d", i), tbl[i].ed, tbl[i].epe, tbl[i].efe);
      idle(37 + i * 5);
    end

    // Break: stop bit low and line held low three more bit times
    ptype = 1'b0;
    send_frame(1'b0, 8'h55, 1'b1, 1'b0, 1'b0, 4);
    idle(2 * BIT);
    chk("break_single_done", q_a.size(), 1);
    expect_a("break", 8'h55, 1'b0, 1'b1);
    send_frame(1'b0, 8'h0F, 1'b1, 1'b0, 1'b1, 1);
    expect_a("after_break", 8'h0F, 1'b0, 1'b0);
    idle(50);

    // Short glitch on the idle line
    saved_d = dout_a;
    saved_e = err_a;
    line_a = 1'b0;
    idle(16);
    line_a = 1'b1;
    idle(3 * BIT);
    chk("glitch_no_done", q_a.size(), 0);
    chk("glitch_data_held", dout_a, saved_d);
    chk("glitch_error_held", err_a, saved_e);

    // Reset during bit 3 of a frame
    drive_bit(1'b0, 1'b0, 1);
    drive_bit(1'b0, 1'b1, 1);
    drive_bit(1'b0, 1'b0, 1);
    drive_bit(1'b0, 1'b1, 1);
    line_a = 1'b0;
    repeat (BIT / 2) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("midrst_data_out", dout_a, 8'h00);
    chk("midrst_rx_done", done_a, 1'b0);
    chk("midrst_parity_error", pe_a, 1'b0);
    chk("midrst_frame_error", fe_a, 1'b0);
    chk("midrst_error", err_a, 1'b0);
    line_a = 1'b1;
    idle(5);
    rst = 1'b1;
    idle(3 * BIT);
    chk("midrst_no_partial", q_a.size(), 0);
    ptype = 1'b1;
    send_frame(1'b0, 8'hA5, 1'b1, 1'b1, 1'b1, 1);
    expect_a("post_rst", 8'hA5, 1'b0, 1'b0);
    idle(20);

    // Randomized frames against the reference model
    for (int k = 0; k < 20; k++) begin
      rd    = 8'($urandom);
      rpt   = 1'($urandom_range(0, 1));
      bad   = ($urandom_range(0, 3) == 0);
      rst_b = ($urandom_range(0, 7) != 0);
      rpb   = model_parity(rd, rpt) ^ bad;
      ptype = rpt;
      send_frame(1'b0, rd, 1'b1, rpb, rst_b, 1);
      expect_a($sformatf("rnd%0d", k), rd, rpb ^ model_parity(rd, rpt), ~rst_b);
      idle($urandom_range(0, 90));
    end

    // No-parity instance: back-to-back frames with no idle gap
    send_frame(1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 1);
    send_frame(1'b1, 8'hC3, 1'b0, 1'b0, 1'b1, 1);
    idle(100);
    chk("b2b_count", q_b.size(), 2);
    if (q_b.size() == 2) begin
      b0 = q_b.pop_front();
      b1 = q_b.pop_front();
      chk("b2b_data0", b0.d, 8'h3C);
      chk("b2b_data1", b1.d, 8'hC3);
      chk("b2b_error0", {b0.pe, b0.fe, b0.er}, 3'b000);
      chk("b2b_error1", {b1.pe, b1.fe, b1.er}, 3'b000);
      chk_rng("b2b_spacing", b1.cyc - b0.cyc, 10 * BIT - 4, 10 * BIT + 4);
    end

    idle(10);
    chk("no_consecutive_done", consec, 0);
    chk("no_spurious_a", q_a.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
